mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-ported memory bus between the instruction-fetch stage and the MEM stage of the 5-stage pipeline. It runs one transaction at a time and gives priority to the data side, because the MEM-stage instruction is older. A starvation guard bounds how long fetch can wait. Per-requester stall outputs feed the hazard logic.

## Interface
- STARVE_LIMIT, 4: consecutive data grants with fetch waiting before fetch is forced a grant (≥1).
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_ready or if_kill.
- if_addr  in  32  fetch address; stable while if_req=1.
- if_kill  in  1  branch flush; discards the fetch in flight or pending.
- if_rdata  out  32  fetched instruction; valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  if_req & ~if_ready.
- mem_req  in  1  data request; held until mem_ready.
- mem_we  in  1  1=store, 0=load.
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- mem_wstrb  in  4  byte enables for stores.
- mem_rdata  out  32  load data; valid when mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse for data.
- mem_stall  out  1  mem_req & ~mem_ready.
- bus_valid  out  1  transaction on bus.
- bus_we  out  1  write enable.
- bus_addr  out  32  address.
- bus_wdata  out  32  write data.
- bus_wstrb  out  4  byte enables; 4'b0000 for fetch and load.
- bus_ready  in  1  bus accepts and completes the transaction this cycle.
- bus_rdata  in  32  read data; valid with bus_ready.

## Operation
- FSM has three states: IDLE, BUS, RESP. A 1-bit owner register records the granted requester (0=IF, 1=MEM).
- IDLE
  - If no request is present, stay in IDLE.
  - Otherwise choose a winner:
    - MEM wins if only mem_req is high, or if both are high and starve_cnt < STARVE_LIMIT.
    - IF wins otherwise.
    - If if_kill=1 in the same cycle, if_req is ignored.
  - Register bus_we, bus_addr, bus_wdata and bus_wstrb from the winner, set owner, go to BUS.
- BUS
  - bus_valid=1; all bus outputs held stable.
  - On bus_ready: capture bus_rdata into the owner's rdata register (0 for stores), go to RESP.
- RESP
  - Pulse the owner's ready for exactly one cycle, then go to IDLE.
  - No grant is made in RESP. This lets the requester drop or change its request before it is sampled again.
- Starvation counter (width $clog2(STARVE_LIMIT+1))
  - Incremented on a MEM grant while if_req=1.
  - Cleared on any IF grant, or on a MEM grant while if_req=0.
  - Saturates at STARVE_LIMIT.
- Fetch kill
  - if_kill in IDLE: no effect beyond suppressing an IF grant that cycle.
  - if_kill in BUS or RESP with owner=IF: the bus transaction still completes (it cannot be aborted) but is marked killed. A killed fetch never produces if_ready; RESP is still traversed.
  - The kill flag clears on return to IDLE.
  - if_kill has no effect when owner=MEM.
- mem_ready and if_ready are never high together.

## Timing
- Reset (asynchronous, immediate): state=IDLE, owner=0, starve_cnt=0, kill flag=0. All outputs are 0: bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb, if_ready, mem_ready, if_rdata, mem_rdata.
- Reset during BUS drops bus_valid without waiting for bus_ready. The lost transaction is never reported.
- Latency with bus_ready high on the first BUS cycle:
  - req sampled in IDLE at cycle t.
  - bus_valid high at t+1.
  - ready pulse at t+2.
  - Next grant possible at t+3. Minimum 3 cycles per transaction.
- Each extra bus wait cycle adds one cycle of latency.
- Stall outputs are combinational from the req inputs and the registered ready signals.

## Test plan
- Single fetch: if_req=1, if_addr=0x100, bus_ready tied 1, bus_rdata=0x00500093 → bus_valid at t+1 with bus_addr=0x100 and bus_wstrb=0; if_ready=1 and if_rdata=0x00500093 at t+2; if_stall=1 at t and t+1.
- Store with wait states: mem_req=1, mem_we=1, addr=0x2000, wdata=0xDEADBEEF, wstrb=4'b0011, bus_ready low for 3 BUS cycles → bus outputs stable for 4 cycles; mem_ready pulses once, the cycle after bus_ready.
- Contention and starvation, STARVE_LIMIT=4: both requests held continuously, MEM re-requesting after every ready → grant order MEM,MEM,MEM,MEM,IF,MEM…; the IF grant occurs exactly after the 4th MEM grant.
- Kill in flight: IF owns the bus with bus_ready held low, if_kill pulsed, then bus_ready=1 → transaction completes on the bus; no if_ready; FSM back in IDLE; a pending mem_req is granted next.
- Simultaneous arrival: if_req and mem_req both rise in the same IDLE cycle with starve_cnt=0 → MEM granted; IF waits; if_stall held high throughout.
- Reset mid-BUS: rstn low while bus_valid=1 → bus_valid=0 immediately; no ready pulse after rstn rises; first post-reset request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-ported memory bus arbiter between fetch (IF) and data (MEM) requesters.
// One transaction at a time, data side preferred, fetch protected by a starvation guard.
//
// state | meaning
// IDLE  | no transaction; arbitrate between requesters
// BUS   | transaction presented on the bus, waiting for bus_ready
// RESP  | one-cycle ready pulse to the owner; no grant made here
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state;
    logic             owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             killed;
    logic             if_ready_r;
    logic             if_eff;
    logic             mem_win;
    logic             any_req;

    assign if_eff  = if_req & ~if_kill;
    assign any_req = mem_req | if_eff;
    assign mem_win = mem_req & (~if_eff | (starve_cnt < CNT_MAX));

    assign bus_valid = (state == ST_BUS);
    // A kill arriving during the ready cycle still suppresses the pulse.
    assign if_ready  = if_ready_r & ~if_kill;
    assign if_stall  = if_req & ~if_ready;
    assign mem_stall = mem_req & ~mem_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
            killed     <= 1'b0;
            if_ready_r <= 1'b0;
            mem_ready  <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_wstrb  <= '0;
        end else begin
            if_ready_r <= 1'b0;
            mem_ready  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state <= ST_BUS;
                        owner <= mem_win;
                        if (mem_win) begin
                            bus_we    <= mem_we;
                            bus_addr  <= mem_addr;
                            bus_wdata <= mem_wdata;
                            bus_wstrb <= mem_we ? mem_wstrb : 4'b0000;
                            if (!if_eff)
                                starve_cnt <= '0;
                            else if (starve_cnt != CNT_MAX)
                                starve_cnt <= starve_cnt + CNT_W'(1);
                        end else begin
                            bus_we     <= 1'b0;
                            bus_addr   <= if_addr;
                            bus_wdata  <= '0;
                            bus_wstrb  <= 4'b0000;
                            starve_cnt <= '0;
                        end
                    end
                end
                ST_BUS: begin
                    if (!owner && if_kill)
                        killed <= 1'b1;
                    if (bus_ready) begin
                        state <= ST_RESP;
                        if (owner) begin
                            mem_rdata <= bus_we ? 32'h0 : bus_rdata;
                            mem_ready <= 1'b1;
                        end else begin
                            if_rdata   <= bus_rdata;
                            if_ready_r <= ~(killed | if_kill);
                        end
                    end
                end
                ST_RESP: begin
                    state  <= ST_IDLE;
                    killed <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
